// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_decoder_if
//  Brief    : Display-bus and result bundle for seg7_scan_decoder. The
//             SEG_DP_EN macro adds the dp_n / dp_out pair.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   an_n;
    logic [4*DIGITS-1:0] digits_out;
    logic [DIGITS-1:0]   digit_valid;
    logic [DIGITS-1:0]   blank;
    logic                frame_valid;
    logic                bad_pattern;
`ifdef SEG_DP_EN
    logic                dp_n;
    logic [DIGITS-1:0]   dp_out;

    modport master (
        output seg_n, an_n, dp_n,
        input  digits_out, digit_valid, blank, frame_valid, bad_pattern, dp_out
    );
    modport slave (
        input  seg_n, an_n, dp_n,
        output digits_out, digit_valid, blank, frame_valid, bad_pattern, dp_out
    );
`else
    modport master (
        output seg_n, an_n,
        input  digits_out, digit_valid, blank, frame_valid, bad_pattern
    );
    modport slave (
        input  seg_n, an_n,
        output digits_out, digit_valid, blank, frame_valid, bad_pattern
    );
`endif
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_decoder
//  Brief    : Monitors a multiplexed active-low 7-segment bus, captures stable
//             patterns per digit and reports complete frames. Optional
//             decimal-point capture is enabled by defining SEG_DP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_decoder_if.slave  bus
);
    localparam int c_cnt_w = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_fire = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_sat  = c_cnt_w'(STABLE_CYCLES);
`ifdef SEG_DP_EN
    localparam int c_pins_w = 8 + DIGITS;
`else
    localparam int c_pins_w = 7 + DIGITS;
`endif

    logic [c_pins_w-1:0] w_pins;
    logic [c_pins_w-1:0] r_s_q;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [4*DIGITS-1:0] r_digits;
    logic [DIGITS-1:0]   r_dv;
    logic [DIGITS-1:0]   r_blank;
    logic                r_frame;
    logic                r_bad;

    logic [DIGITS-1:0]   w_an;
    logic                w_onehot;
    logic                w_same;
    logic                w_cap;
    logic                w_good;
    logic [3:0]          w_nib;
    logic                w_match;
    logic                w_blank;
    logic [DIGITS-1:0]   w_set;
    logic [DIGITS-1:0]   w_dv_next;
    logic                w_frame;

`ifdef SEG_DP_EN
    logic [DIGITS-1:0]   r_dp;
    assign w_pins     = {bus.dp_n, bus.seg_n, bus.an_n};
    assign bus.dp_out = r_dp;
`else
    assign w_pins     = {bus.seg_n, bus.an_n};
`endif

    assign w_an     = ~bus.an_n;
    assign w_onehot = (w_an != '0) && ((w_an & (w_an - DIGITS'(1))) == '0);
    assign w_same   = (w_pins == r_s_q);
    assign w_cap    = w_same && (r_cnt == c_fire) && w_onehot;
    assign w_blank  = (bus.seg_n == 7'b1111111);

    always_comb begin
        w_nib   = 4'h0;
        w_match = 1'b1;
        case (bus.seg_n)
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1111000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0000011: w_nib = 4'hB;
            7'b1000110: w_nib = 4'hC;
            7'b0100001: w_nib = 4'hD;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            default:    w_match = 1'b0;
        endcase
    end

    // The frame pulse clears digit_valid one edge later; a fresh capture on
    // that same edge still survives the clear.
    assign w_good    = w_cap && (w_match || w_blank);
    assign w_set     = w_good ? w_an : '0;
    assign w_dv_next = (r_frame ? '0 : r_dv) | w_set;
    assign w_frame   = w_good && (&w_dv_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_q   <= '1;
            r_cnt   <= '0;
            r_dv    <= '0;
            r_frame <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_s_q   <= w_pins;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != c_sat) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            r_dv    <= w_dv_next;
            r_frame <= w_frame;
            r_bad   <= w_cap && !w_match && !w_blank;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= '0;
            r_blank  <= '0;
`ifdef SEG_DP_EN
            r_dp     <= '0;
`endif
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_set[i]) begin
                    r_digits[4*i +: 4] <= w_blank ? 4'h0 : w_nib;
                    r_blank[i]         <= w_blank;
`ifdef SEG_DP_EN
                    r_dp[i]            <= ~bus.dp_n;
`endif
                end
            end
        end
    end

    assign bus.digits_out  = r_digits;
    assign bus.digit_valid = r_dv;
    assign bus.blank       = r_blank;
    assign bus.frame_valid = r_frame;
    assign bus.bad_pattern = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_decoder
//  Brief    : Scoreboard bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;
    localparam int C_DIGITS = 4;
    localparam int C_STABLE = 8;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dv;
        logic [3:0]  blank;
        logic        fv;
        logic        bad;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    // Reference model state
    logic [15:0] m_digits;
    logic [3:0]  m_dv;
    logic [3:0]  m_blank;
    logic        m_fv;
    logic        m_bad;
    logic [10:0] m_prev;
    int          m_age;
    logic [6:0]  tbl [16];

    seg7_scan_decoder_if #(.DIGITS(C_DIGITS)) bus ();

    seg7_scan_decoder #(
        .DIGITS        (C_DIGITS),
        .STABLE_CYCLES (C_STABLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [6:0] s, input logic [3:0] a);
        logic       fire;
        int         zeros;
        int         idx;
        int         nib;
        if (r) begin
            m_digits = '0; m_dv = '0; m_blank = '0; m_fv = 1'b0; m_bad = 1'b0;
            m_prev   = '1; m_age = 0;
            return;
        end
        fire = 1'b0;
        if ({s, a} != m_prev) begin
            m_prev = {s, a};
            m_age  = 0;
        end else begin
            if (m_age == C_STABLE - 1) fire = 1'b1;
            if (m_age < C_STABLE) m_age++;
        end
        if (m_fv) m_dv = '0;
        m_fv  = 1'b0;
        m_bad = 1'b0;
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; idx = i; end
        if (fire && zeros == 1) begin
            nib = -1;
            for (int k = 0; k < 16; k++) if (tbl[k] == s) nib = k;
            if (nib >= 0 || s == 7'b1111111) begin
                m_digits[4*idx +: 4] = (nib >= 0) ? 4'(nib) : 4'h0;
                m_blank[idx]         = (nib < 0);
                m_dv[idx]            = 1'b1;
                m_fv                 = (m_dv == 4'hF);
            end else begin
                m_bad = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] s, input logic [3:0] a);
        @(negedge clk);
        rst       = r;
        bus.seg_n = s;
        bus.an_n  = a;
        model_edge(r, s, a);
        sb_q.push_back('{digits: m_digits, dv: m_dv, blank: m_blank, fv: m_fv, bad: m_bad});
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
        repeat (n) drive(1'b0, s, a);
    endtask

    // Monitor: pop one expectation per edge that had stimulus behind it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("digits_out",  32'(bus.digits_out),  32'(e.digits));
                check("digit_valid", 32'(bus.digit_valid), 32'(e.dv));
                check("blank",       32'(bus.blank),       32'(e.blank));
                check("frame_valid", 32'(bus.frame_valid), 32'(e.fv));
                check("bad_pattern", 32'(bus.bad_pattern), 32'(e.bad));
            end
        end
    end

`ifdef SEG_DP_EN
    initial bus.dp_n = 1'b1;
`endif

    initial begin
        int        frames;
        logic [6:0] s;
        logic [3:0] a;
        n_checks = 0;
        n_errors = 0;
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst       = 1'b1;
        bus.seg_n = '1;
        bus.an_n  = '1;
        model_edge(1'b1, 7'h7F, 4'hF);

        // Reset with random pins, then idle
        repeat (3) drive(1'b1, 7'($urandom), 4'($urandom));
        hold(7'h7F, 4'hF, 12);

        // Single digit capture, long hold without re-fire
        hold(7'b0110000, 4'b1110, 31);

        // Short glitch then real pattern
        hold(7'b1111001, 4'b1101, 5);
        hold(7'b0100100, 4'b1101, 9);

        // Full scan A,B,C,D with a frame-pulse count
        frames = 0;
        fork
            begin
                hold(7'b0001000, 4'b1110, 9);
                hold(7'b0000011, 4'b1101, 9);
                hold(7'b1000110, 4'b1011, 9);
                hold(7'b0100001, 4'b0111, 9);
                hold(7'h7F, 4'hF, 3);
            end
            begin
                repeat (40) begin
                    @(posedge clk); #2;
                    if (bus.frame_valid) frames++;
                end
            end
        join
        check("frame_count", 32'(frames), 32'd1);
        check("frame_digits", 32'(bus.digits_out), 32'h0000DCBA);

        // Invalid pattern, then blank on digit 1
        hold(7'b0101010, 4'b1101, 9);
        hold(7'b1111111, 4'b1101, 9);

        // Two anodes low is ignored; reset mid-scan
        hold(7'b0011001, 4'b1100, 9);
        hold(7'b0011001, 4'b1110, 9);
        hold(7'b0010010, 4'b1101, 9);
        repeat (2) drive(1'b1, 7'h7F, 4'hF);
        hold(7'h7F, 4'hF, 10);

        // Randomised scan mix
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(5))
                0:       s = 7'b1111111;
                1:       s = 7'($urandom);
                default: s = tbl[$urandom_range(15)];
            endcase
            a = ~(4'b0001 << $urandom_range(3));
            if ($urandom_range(9) == 0) a = 4'($urandom);
            hold(s, a, $urandom_range(4, 11));
        end

        repeat (2) @(posedge clk);
        #2;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
